// File: rtl/parity_serial_tx.sv
// Parity-framed serial transmitter: start bit, LSB-first data, parity bit, stop bit.
// Define PARITY_ODD_EN for odd parity; the default build uses even parity.
module parity_serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_line,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                tx_line_q, tx_line_d;
    logic                tx_busy_q, tx_busy_d;
    logic                frame_done_q, frame_done_d;
    logic                in_parity;
    logic                accept;
    logic                bit_end;

    // Parity bit chosen so the receiver's check over data plus parity comes out clean
`ifdef PARITY_ODD_EN
    assign in_parity = ~^in_data;
`else
    assign in_parity = ^in_data;
`endif

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign bit_end  = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_line_q    <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_line_q    <= tx_line_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state; registered outputs are decoded from the next state so they line up with it
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tx_line_d    = 1'b1;
        tx_busy_d    = 1'b0;
        frame_done_d = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (accept) begin
                    shift_d  = in_data;
                    parity_d = in_parity;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = shift_d[0];
            S_PARITY: tx_line_d = parity_d;
            default:  tx_line_d = 1'b1;
        endcase

        tx_busy_d    = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    assign tx_line    = tx_line_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench for parity_serial_tx: stimulus queues expected frames, a monitor checks the line.
module tb_parity_serial_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int TOTAL = (DW + 3) * CPB;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx_line;
    logic          tx_busy;
    logic          frame_done;

    parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_line    (tx_line),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   in_frame = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endfunction

    // Reference parity from a count of ones, not a reduction
    function automatic logic model_par(input logic [DW-1:0] w);
        logic p;
        p = logic'($countones(w) % 2);
`ifdef PARITY_ODD_EN
        p = ~p;
`endif
        return p;
    endfunction

    function automatic logic want_odd();
`ifdef PARITY_ODD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: one check set per cycle, frame content compared when the stop bit ends
    initial begin
        exp_t            cur;
        int              fc;
        int              bi;
        logic [DW+2:0]   fv;
        logic [DW+2:0]   rec;
        logic [DW-1:0]   rd;
        fc  = 0;
        rec = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                in_frame = 0;
            end else begin
                if (!in_frame && q.size() > 0 && cyc > q[0].acc) begin
                    chk("start_missed", 32'(cyc), 32'(q[0].acc));
                    void'(q.pop_front());
                end
                if (!in_frame && q.size() > 0 && cyc == q[0].acc) begin
                    cur      = q.pop_front();
                    in_frame = 1;
                    fc       = 1;
                end
                if (in_frame) begin
                    fv = {1'b1, cur.par, cur.data, 1'b0};
                    bi = (fc - 1) / CPB;
                    chk("line", 32'(tx_line), 32'(fv[bi]));
                    chk("busy", 32'(tx_busy), 32'(1));
                    chk("ready_busy", 32'(in_ready), 32'(0));
                    chk("frame_done", 32'(frame_done), 32'(fc == TOTAL));
                    if (fc % CPB == 0) rec[bi] = tx_line;
                    if (fc == TOTAL) begin
                        rd = rec[DW:1];
                        chk("word", 32'(rd), 32'(cur.data));
                        chk("parity", 32'(rec[DW+1]), 32'(cur.par));
                        chk("xor_sum", 32'($countones({rd, rec[DW+1]}) % 2), 32'(want_odd()));
                        in_frame = 0;
                    end
                    fc++;
                end else begin
                    chk("idle_line", 32'(tx_line), 32'(1));
                    chk("idle_busy", 32'(tx_busy), 32'(0));
                    chk("idle_done", 32'(frame_done), 32'(0));
                    chk("idle_ready", 32'(in_ready), 32'(1));
                end
            end
        end
    end

    // Offer a word at a negedge; when accepted, queue its expected frame
    task automatic send(input logic [DW-1:0] w, input bit keep, input logic [DW-1:0] after,
                        output int acc);
        int t;
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(0), 32'(1));
            acc = -1;
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        q.push_back('{data: w, par: model_par(w), acc: acc});
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
        in_data = after;
    endtask

    initial begin
        int       a1;
        int       a2;
        int       t;
        int       gap;
        bit       keep;
        logic [DW-1:0] w;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        chk("rst_line", 32'(tx_line), 32'(1));
        chk("rst_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(tx_busy), 32'(0));
        chk("rst_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        send(8'h00, 1'b0, 8'h00, a1);
        send(8'h01, 1'b1, 8'h01, a1);
        send(8'h03, 1'b0, 8'h03, a2);
        chk("b2b_period", 32'(a2 - a1), 32'(TOTAL + 1));
        send(8'hA5, 1'b0, 8'hFF, a1);
        send(8'hFF, 1'b0, 8'h00, a1);

        send(8'h3C, 1'b0, 8'hC3, a1);
        while (cyc < a1 + 19) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_line", 32'(tx_line), 32'(1));
        chk("midrst_busy", 32'(tx_busy), 32'(0));
        chk("midrst_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h55, 1'b0, 8'hAA, a1);

        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            w    = DW'($urandom);
            keep = ($urandom_range(0, 3) == 0) && (i != 19);
            send(w, keep, DW'($urandom), a1);
        end

        t = 0;
        while ((q.size() > 0 || in_frame) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size() == 0 && !in_frame), 32'(1));
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
